ddr3_tl_arbiter: RTL and testbench

Two-master TileLink-UH arbiter that shares the single DDR3 adapter A/D port between two requesters (e.g. CPU data-cache refill path and display/DMA engine). Grants A-channel whole messages round-robin, holds the grant for all 8 beats of a PutFull burst, and tags the forwarded source with the master index. D-channel responses are demultiplexed back by that tag. Sits directly upstream of the DDR3 adapter; adds no latency on either channel.

---
 rtl/ddr3_tl_pkg.sv | 17 +
 rtl/ddr3_tl_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ddr3_tl_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_tl_pkg.sv
// Shared TileLink-UH constants and arbiter state type for the DDR3 front end.
package ddr3_tl_pkg;

    localparam logic [2:0] TL_GET           = 3'd4;
    localparam logic [2:0] TL_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

    localparam int BEATS_PER_BURST = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ddr3_tl_arbiter.sv
// Two-master round-robin TileLink-UH arbiter in front of the DDR3 adapter.
// A channel is granted per whole message; D channel is routed back by the source tag MSB.
module ddr3_tl_arbiter
    import ddr3_tl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 28,
    parameter int SOURCE_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      m0_a_valid,
    output logic                      m0_a_ready,
    input  logic [2:0]                m0_a_opcode,
    input  logic [SOURCE_WIDTH-1:0]   m0_a_source,
    input  logic [ADDRESS_WIDTH-1:0]  m0_a_address,
    input  logic [63:0]               m0_a_data,

    input  logic                      m1_a_valid,
    output logic                      m1_a_ready,
    input  logic [2:0]                m1_a_opcode,
    input  logic [SOURCE_WIDTH-1:0]   m1_a_source,
    input  logic [ADDRESS_WIDTH-1:0]  m1_a_address,
    input  logic [63:0]               m1_a_data,

    output logic                      s_a_valid,
    input  logic                      s_a_ready,
    output logic [2:0]                s_a_opcode,
    output logic [SOURCE_WIDTH:0]     s_a_source,
    output logic [ADDRESS_WIDTH-1:0]  s_a_address,
    output logic [63:0]               s_a_data,

    input  logic                      s_d_valid,
    output logic                      s_d_ready,
    input  logic [2:0]                s_d_opcode,
    input  logic [SOURCE_WIDTH:0]     s_d_source,
    input  logic [63:0]               s_d_data,

    output logic                      m0_d_valid,
    input  logic                      m0_d_ready,
    output logic [2:0]                m0_d_opcode,
    output logic [SOURCE_WIDTH-1:0]   m0_d_source,
    output logic [63:0]               m0_d_data,

    output logic                      m1_d_valid,
    input  logic                      m1_d_ready,
    output logic [2:0]                m1_d_opcode,
    output logic [SOURCE_WIDTH-1:0]   m1_d_source,
    output logic [63:0]               m1_d_data
);

    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_BURST - 1);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_grant;
    logic       w_grant_next;
    logic       r_rr_last;
    logic       w_rr_last_next;
    logic [2:0] r_beat;
    logic [2:0] w_beat_next;

    logic       w_cand;
    logic       w_sel;
    logic       w_fire;
    logic       w_is_put;
    logic       w_d_idx;

    // Tie goes to the master that did not finish the previous message.
    always_comb begin
        w_cand = 1'b0;
        if (m0_a_valid && m1_a_valid) begin
            w_cand = ~r_rr_last;
        end else if (m1_a_valid) begin
            w_cand = 1'b1;
        end
    end

    // Only IDLE may pick a new master; HOLD and BURST are locked to r_grant.
    assign w_sel = (r_state == ST_IDLE) ? w_cand : r_grant;

    assign s_a_valid   = w_sel ? m1_a_valid   : m0_a_valid;
    assign s_a_opcode  = w_sel ? m1_a_opcode  : m0_a_opcode;
    assign s_a_source  = {w_sel, (w_sel ? m1_a_source : m0_a_source)};
    assign s_a_address = w_sel ? m1_a_address : m0_a_address;
    assign s_a_data    = w_sel ? m1_a_data    : m0_a_data;
    assign m0_a_ready  = ~w_sel & s_a_ready;
    assign m1_a_ready  =  w_sel & s_a_ready;

    assign w_fire   = s_a_valid & s_a_ready;
    assign w_is_put = (s_a_opcode == TL_PUTFULL);

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_last_next = r_rr_last;
        w_beat_next    = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (w_is_put) begin
                        w_state_next = ST_BURST;
                        w_grant_next = w_sel;
                        w_beat_next  = 3'd1;
                    end else begin
                        w_rr_last_next = w_sel;
                    end
                end else if (s_a_valid) begin
                    w_state_next = ST_HOLD;
                    w_grant_next = w_sel;
                end
            end
            ST_HOLD: begin
                if (w_fire) begin
                    if (w_is_put) begin
                        w_state_next = ST_BURST;
                        w_beat_next  = 3'd1;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_rr_last_next = r_grant;
                    end
                end
            end
            ST_BURST: begin
                if (w_fire) begin
                    if (r_beat == LAST_BEAT) begin
                        w_state_next   = ST_IDLE;
                        w_beat_next    = 3'd0;
                        w_rr_last_next = r_grant;
                    end else begin
                        w_beat_next = r_beat + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_beat_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_rr_last <= 1'b1;
            r_beat    <= 3'd0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_rr_last <= w_rr_last_next;
            r_beat    <= w_beat_next;
        end
    end

    // D channel: stateless demux on the tag bit added on the A side.
    assign w_d_idx     = s_d_source[SOURCE_WIDTH];
    assign m0_d_valid  = s_d_valid & ~w_d_idx;
    assign m1_d_valid  = s_d_valid &  w_d_idx;
    assign s_d_ready   = w_d_idx ? m1_d_ready : m0_d_ready;
    assign m0_d_opcode = s_d_opcode;
    assign m1_d_opcode = s_d_opcode;
    assign m0_d_source = s_d_source[SOURCE_WIDTH-1:0];
    assign m1_d_source = s_d_source[SOURCE_WIDTH-1:0];
    assign m0_d_data   = s_d_data;
    assign m1_d_data   = s_d_data;

endmodule

// File: tb/tb_ddr3_tl_arbiter.sv
// Randomized scoreboard bench for ddr3_tl_arbiter: message-level arbitration model
// feeds expected A beats and D routing into queues; a monitor pops and compares.
module tb_ddr3_tl_arbiter;
    import ddr3_tl_pkg::*;

    localparam int AW = 28;
    localparam int SW = 4;
    localparam int N_CYCLES = 2000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
    logic [2:0]      m0_a_opcode, m1_a_opcode;
    logic [SW-1:0]   m0_a_source, m1_a_source;
    logic [AW-1:0]   m0_a_address, m1_a_address;
    logic [63:0]     m0_a_data, m1_a_data;
    logic            s_a_valid, s_a_ready;
    logic [2:0]      s_a_opcode;
    logic [SW:0]     s_a_source;
    logic [AW-1:0]   s_a_address;
    logic [63:0]     s_a_data;
    logic            s_d_valid, s_d_ready;
    logic [2:0]      s_d_opcode;
    logic [SW:0]     s_d_source;
    logic [63:0]     s_d_data;
    logic            m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
    logic [2:0]      m0_d_opcode, m1_d_opcode;
    logic [SW-1:0]   m0_d_source, m1_d_source;
    logic [63:0]     m0_d_data, m1_d_data;

    ddr3_tl_arbiter #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_data(m0_a_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_data(m1_a_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_source(s_d_source), .s_d_data(s_d_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_source(m0_d_source), .m0_d_data(m0_d_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_source(m1_d_source), .m1_d_data(m1_d_data)
    );

    typedef struct {
        logic [2:0]    op;
        logic [SW:0]   src;
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } abeat_t;

    typedef struct {
        logic          v0;
        logic          v1;
        logic          sready;
        logic [2:0]    op;
        logic [SW-1:0] src;
        logic [63:0]   data;
    } dexp_t;

    abeat_t exp_q[$];
    dexp_t  dexp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    bit     start = 1'b0;

    // Per-master message state: the message currently being offered and how many beats went out.
    logic [2:0]    cur_op[2];
    logic [SW-1:0] cur_src[2];
    logic [AW-1:0] cur_addr[2];
    logic [63:0]   cur_data[2];
    int            beat[2];
    bit            hold[2];
    int            owner = -1;
    int            rr_last = 1;
    int            n_resets = 0;
    int            n_msgs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int msg_len(input logic [2:0] op);
        return (op == TL_PUTFULL) ? BEATS_PER_BURST : 1;
    endfunction

    task automatic new_msg(input int m);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[5:0] = 6'd0;
        cur_op[m]   = ($urandom_range(0, 1) == 1) ? TL_GET : TL_PUTFULL;
        cur_src[m]  = SW'($urandom_range(0, 15));
        cur_addr[m] = a;
        cur_data[m] = {$urandom, $urandom};
        beat[m]     = 0;
    endtask

    task automatic idle_inputs();
        m0_a_valid = 1'b0; m0_a_opcode = 3'd0; m0_a_source = '0; m0_a_address = '0; m0_a_data = '0;
        m1_a_valid = 1'b0; m1_a_opcode = 3'd0; m1_a_source = '0; m1_a_address = '0; m1_a_data = '0;
        s_a_ready = 1'b0;
        s_d_valid = 1'b0; s_d_opcode = 3'd0; s_d_source = '0; s_d_data = '0;
        m0_d_ready = 1'b0; m1_d_ready = 1'b0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_s_a_valid"},  64'(s_a_valid),  64'd0);
        check({tag, "_m0_a_ready"}, 64'(m0_a_ready), 64'd0);
        check({tag, "_m1_a_ready"}, 64'(m1_a_ready), 64'd0);
        check({tag, "_m0_d_valid"}, 64'(m0_d_valid), 64'd0);
        check({tag, "_m1_d_valid"}, 64'(m1_d_valid), 64'd0);
        check({tag, "_s_d_ready"},  64'(s_d_ready),  64'd0);
    endtask

    task automatic push_d_expect();
        dexp_t d;
        d.v0     = s_d_valid && !s_d_source[SW];
        d.v1     = s_d_valid &&  s_d_source[SW];
        d.sready = s_d_source[SW] ? m1_d_ready : m0_d_ready;
        d.op     = s_d_opcode;
        d.src    = s_d_source[SW-1:0];
        d.data   = s_d_data;
        dexp_q.push_back(d);
    endtask

    // Stimulus and reference model.
    initial begin
        abeat_t e;
        int     done_m;
        idle_inputs();
        new_msg(0);
        new_msg(1);
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_quiet("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_all_quiet("post_reset");
        @(posedge clk);
        start = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            reset_n = 1'b1;

            // Pull reset once a PutFull has sent beats 0..3; that burst restarts from beat 0.
            if (owner >= 0 && cur_op[owner] == TL_PUTFULL && beat[owner] == 4 && n_resets < 3) begin
                n_resets++;
                reset_n = 1'b0;
                idle_inputs();
                beat[owner] = 0;
                hold[0] = 1'b0;
                hold[1] = 1'b0;
                owner   = -1;
                rr_last = 1;
                #1;
                check_all_quiet("midburst_reset");
                push_d_expect();
                continue;
            end

            for (int m = 0; m < 2; m++) begin
                if (!hold[m] && $urandom_range(0, 99) < 55) hold[m] = 1'b1;
            end
            m0_a_valid = hold[0]; m0_a_opcode = cur_op[0]; m0_a_source = cur_src[0];
            m0_a_address = cur_addr[0]; m0_a_data = cur_data[0];
            m1_a_valid = hold[1]; m1_a_opcode = cur_op[1]; m1_a_source = cur_src[1];
            m1_a_address = cur_addr[1]; m1_a_data = cur_data[1];
            s_a_ready  = ($urandom_range(0, 99) < 65);

            s_d_valid  = ($urandom_range(0, 99) < 50);
            s_d_opcode = ($urandom_range(0, 1) == 1) ? TL_ACCESSACKDATA : TL_ACCESSACK;
            s_d_source = (SW+1)'($urandom_range(0, 31));
            s_d_data   = {$urandom, $urandom};
            m0_d_ready = 1'($urandom_range(0, 1));
            m1_d_ready = 1'($urandom_range(0, 1));
            #1;

            // A message, once offered, owns the slave port until its last beat is accepted.
            if (owner < 0) begin
                if (hold[0] && hold[1]) owner = (rr_last == 1) ? 0 : 1;
                else if (hold[0])       owner = 0;
                else if (hold[1])       owner = 1;
            end

            if (owner >= 0) begin
                check("s_a_valid",  64'(s_a_valid),  64'(hold[owner]));
                check("m0_a_ready", 64'(m0_a_ready), 64'((owner == 0) && s_a_ready));
                check("m1_a_ready", 64'(m1_a_ready), 64'((owner == 1) && s_a_ready));
            end else begin
                check("s_a_valid_idle", 64'(s_a_valid), 64'd0);
            end

            push_d_expect();

            if (owner >= 0 && hold[owner] && s_a_ready) begin
                e.op   = cur_op[owner];
                e.src  = {1'(owner), cur_src[owner]};
                e.addr = cur_addr[owner];
                e.data = cur_data[owner];
                exp_q.push_back(e);
                hold[owner] = 1'b0;
                beat[owner]++;
                cur_data[owner] = {$urandom, $urandom};
                if (beat[owner] == msg_len(cur_op[owner])) begin
                    rr_last = owner;
                    done_m  = owner;
                    owner   = -1;
                    n_msgs++;
                    new_msg(done_m);
                end
            end
        end

        @(negedge clk);
        start = 1'b0;
        idle_inputs();
        #5;
        check("a_queue_drained", 64'(exp_q.size()),  64'd0);
        check("d_queue_drained", 64'(dexp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Monitor: pops expectations whenever the DUT presents an A beat, and one D record per cycle.
    initial begin
        abeat_t e;
        dexp_t  d;
        wait (start);
        forever begin
            @(negedge clk);
            #2;
            if (!start) break;
            if (s_a_valid && s_a_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_a_beat", 64'(s_a_source), 64'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("s_a_opcode",  64'(s_a_opcode),  64'(e.op));
                    check("s_a_source",  64'(s_a_source),  64'(e.src));
                    check("s_a_address", 64'(s_a_address), 64'(e.addr));
                    check("s_a_data",    s_a_data,         e.data);
                    $display("A beat t=%0t op=%0d src=%h addr=%h data=%h", $time,
                             s_a_opcode, s_a_source, s_a_address, s_a_data);
                end
            end
            if (dexp_q.size() == 0) begin
                check("d_record_missing", 64'(dexp_q.size()), 64'd1);
            end else begin
                d = dexp_q.pop_front();
                check("m0_d_valid",  64'(m0_d_valid),  64'(d.v0));
                check("m1_d_valid",  64'(m1_d_valid),  64'(d.v1));
                check("s_d_ready",   64'(s_d_ready),   64'(d.sready));
                check("m0_d_opcode", 64'(m0_d_opcode), 64'(d.op));
                check("m1_d_opcode", 64'(m1_d_opcode), 64'(d.op));
                check("m0_d_source", 64'(m0_d_source), 64'(d.src));
                check("m1_d_source", 64'(m1_d_source), 64'(d.src));
                check("m0_d_data",   m0_d_data,        d.data);
                check("m1_d_data",   m1_d_data,        d.data);
            end
        end
    end

endmodule
